// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, the NOP encoding and the pipeline stage record
// used by the instruction-memory fetch pipe.
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam int BYTE_W = 8;
  // Address width carried through the pipe; the fetch pipe supports ADDR_W up to this.
  localparam int STAGE_ADDR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic                    valid;
    logic [INSTR_W-1:0]      instr;
    logic [STAGE_ADDR_W-1:0] addr;
    logic                    err;
  } stage_t;

endpackage

// File: rtl/imem_fetch_pipe_if.sv
// imem_fetch_pipe_if: fetch request/response handshake plus the byte loader.
// master = PC/fetch side (and loader), slave = the instruction memory.
interface imem_fetch_pipe_if #(
  parameter int ADDR_W = 32
);
  import imem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic                 flush;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [INSTR_W-1:0]   resp_instr;
  logic [ADDR_W-1:0]    resp_addr;
  logic                 resp_err;
  logic                 ld_en;
  logic [ADDR_W-1:0]    ld_addr;
  logic [BYTE_W-1:0]    ld_data;

  modport master (
    output req_valid, req_addr, flush, resp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, resp_ready, ld_en, ld_addr, ld_data,
    output req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

endinterface

// File: rtl/imem_stage_reg.sv
// imem_stage_reg: one fetch pipeline register. Reset zeroes the whole record,
// clear (flush) drops only the valid bit, hold freezes the stage.
module imem_stage_reg
  import imem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   clear,
  input  stage_t d,
  output stage_t q
);

  stage_t q_reg;

  // Stage update: reset beats clear, clear beats hold, otherwise load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (clear) begin
      q_reg.valid <= 1'b0;
    end else if (!hold) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/imem_fetch_pipe.sv
// imem_fetch_pipe: byte-addressed instruction memory with a pipelined,
// handshaked fetch port (LATENCY stages, 1..4) and a byte-wide program loader.
// Words are assembled big-endian from four consecutive bytes.
// Build option IMEM_ERR_EN: when defined, misaligned or out-of-range fetches
// return NOP with resp_err=1; when undefined resp_err stays 0, the low address
// bits are used as given and bytes past the end of memory read as 8'h00.
module imem_fetch_pipe
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 144,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1
) (
  input  logic             clk,
  input  logic             reset,
  imem_fetch_pipe_if.slave bus
);

  localparam int MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  // One extra bit so that addr+3 never wraps.
  localparam int EXT_W = ADDR_W + 1;
  localparam logic [EXT_W-1:0] DEPTH_EXT = EXT_W'(DEPTH_BYTES);
`ifdef IMEM_ERR_EN
  localparam logic [EXT_W-1:0] LAST_WORD_EXT = EXT_W'(DEPTH_BYTES - 4);
`endif

  logic [BYTE_W-1:0]  mem [DEPTH_BYTES];
  logic [EXT_W-1:0]   req_ext;
  logic [BYTE_W-1:0]  byte_val [4];
  logic [INSTR_W-1:0] word_next;
  logic               err_next;
  logic               stall;
  logic               accept;
  stage_t             stage_in;
  stage_t             stage_q [LATENCY];

  // Handshake: the whole pipe freezes while the consumer refuses the head.
  assign stall         = stage_q[LATENCY-1].valid && !bus.resp_ready;
  assign bus.req_ready = !reset && !bus.flush && !bus.ld_en && !stall;
  assign accept        = bus.req_valid && bus.req_ready;

  // Program loader: out-of-range byte writes are dropped.
  always_ff @(posedge clk) begin
    if (bus.ld_en && ({1'b0, bus.ld_addr} < DEPTH_EXT)) begin
      mem[bus.ld_addr[MEM_AW-1:0]] <= bus.ld_data;
    end
  end

  assign req_ext = {1'b0, bus.req_addr};

  // Byte lanes a..a+3; an index past the end never touches the array.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [EXT_W-1:0] idx;
    assign idx          = req_ext + EXT_W'(gi);
    assign byte_val[gi] = (idx < DEPTH_EXT) ? mem[idx[MEM_AW-1:0]] : '0;
  end

`ifdef IMEM_ERR_EN
  assign err_next = (bus.req_addr[1:0] != 2'b00) || (req_ext > LAST_WORD_EXT);
`else
  assign err_next = 1'b0;
`endif

  assign word_next = err_next ? NOP_INSTR
                              : {byte_val[0], byte_val[1], byte_val[2], byte_val[3]};

  // Record entering stage 1; valid only on an accepted request.
  always_comb begin
    stage_in       = '0;
    stage_in.valid = accept;
    stage_in.instr = word_next;
    stage_in.addr  = STAGE_ADDR_W'(bus.req_addr);
    stage_in.err   = err_next;
  end

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    stage_t d;
    if (gi == 0) begin : g_first
      assign d = stage_in;
    end else begin : g_next
      assign d = stage_q[gi-1];
    end
    imem_stage_reg u_reg (
      .clk   (clk),
      .reset (reset),
      .hold  (stall),
      .clear (bus.flush),
      .d     (d),
      .q     (stage_q[gi])
    );
  end

  assign bus.resp_valid = stage_q[LATENCY-1].valid;
  assign bus.resp_instr = stage_q[LATENCY-1].instr;
  assign bus.resp_addr  = stage_q[LATENCY-1].addr[ADDR_W-1:0];
  assign bus.resp_err   = stage_q[LATENCY-1].err;

endmodule

// File: tb/tb_imem_fetch_pipe.sv
// tb_imem_fetch_pipe: directed bench for imem_fetch_pipe with one LATENCY=1
// and one LATENCY=3 instance sharing clock, reset and program image.
// Error-path expectations follow the IMEM_ERR_EN build option.
module tb_imem_fetch_pipe;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;

  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h8C09_0004;
  localparam logic [31:0] W2 = 32'h1122_3344;
  localparam logic [31:0] W3 = 32'hA55A_0FF0;

  imem_fetch_pipe_if #(.ADDR_W(32)) bus1 ();
  imem_fetch_pipe_if #(.ADDR_W(32)) bus3 ();

  imem_fetch_pipe #(.DEPTH_BYTES(144), .ADDR_W(32), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  imem_fetch_pipe #(.DEPTH_BYTES(144), .ADDR_W(32), .LATENCY(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [7:0] d);
    bus1.ld_en = 1'b1; bus1.ld_addr = a; bus1.ld_data = d;
    bus3.ld_en = 1'b1; bus3.ld_addr = a; bus3.ld_data = d;
    step();
    bus1.ld_en = 1'b0;
    bus3.ld_en = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] a, input logic e);
    check({tag, ".valid"}, 64'(bus1.resp_valid), 64'(v));
    if (v) begin
      check({tag, ".instr"}, 64'(bus1.resp_instr), 64'(ins));
      check({tag, ".addr"},  64'(bus1.resp_addr),  64'(a));
      check({tag, ".err"},   64'(bus1.resp_err),   64'(e));
    end
  endtask

  task automatic chk3(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] a);
    check({tag, ".valid"}, 64'(bus3.resp_valid), 64'(v));
    if (v) begin
      check({tag, ".instr"}, 64'(bus3.resp_instr), 64'(ins));
      check({tag, ".addr"},  64'(bus3.resp_addr),  64'(a));
      check({tag, ".err"},   64'(bus3.resp_err),   64'd0);
    end
  endtask

  initial begin
    logic [31:0] img [16];
    logic [31:0] words [4];
    n_total = 0; n_pass = 0; n_fail = 0;
    reset = 1'b1;
    bus1.req_valid = 0; bus1.req_addr = 0; bus1.flush = 0; bus1.resp_ready = 1;
    bus1.ld_en = 0; bus1.ld_addr = 0; bus1.ld_data = 0;
    bus3.req_valid = 0; bus3.req_addr = 0; bus3.flush = 0; bus3.resp_ready = 1;
    bus3.ld_en = 0; bus3.ld_addr = 0; bus3.ld_data = 0;
    img = '{32'h20, 32'h08, 32'h00, 32'h05, 32'h8C, 32'h09, 32'h00, 32'h04,
            32'h11, 32'h22, 32'h33, 32'h44, 32'hA5, 32'h5A, 32'h0F, 32'hF0};
    words = '{W0, W1, W2, W3};

    // Reset state
    step(); step();
    check("rst.valid1", 64'(bus1.resp_valid), 64'd0);
    check("rst.instr1", 64'(bus1.resp_instr), 64'd0);
    check("rst.addr1",  64'(bus1.resp_addr),  64'd0);
    check("rst.err1",   64'(bus1.resp_err),   64'd0);
    check("rst.valid3", 64'(bus3.resp_valid), 64'd0);
    check("rst.instr3", 64'(bus3.resp_instr), 64'd0);
    check("rst.ready1", 64'(bus1.req_ready),  64'd0);
    reset = 1'b0;
    #1;
    check("idle.ready1", 64'(bus1.req_ready), 64'd1);

    // Program load; req_ready must drop while the loader is active
    bus1.ld_en = 1'b1; #1;
    check("ld.ready1", 64'(bus1.req_ready), 64'd0);
    bus1.ld_en = 1'b0;
    for (int i = 0; i < 16; i++) load(32'(i), img[i][7:0]);
    load(32'd140, 8'hDE); load(32'd141, 8'hAD);
    load(32'd142, 8'hBE); load(32'd143, 8'hEF);
    load(32'd256, 8'hFF);  // out of range: must not alias onto byte 0

    // LATENCY=1 back-to-back fetches
    bus1.req_valid = 1; bus1.req_addr = 0; #1;
    check("l1.ready", 64'(bus1.req_ready), 64'd1);
    step(); chk1("l1.a0", 1, W0, 0, 0);
    bus1.req_addr = 4;
    step(); chk1("l1.a4", 1, W1, 4, 0);
    bus1.req_valid = 0;
    step(); chk1("l1.idle", 0, 0, 0, 0);

    // LATENCY=3 single fetch latency
    bus3.req_valid = 1; bus3.req_addr = 0;
    step(); chk3("l3.t1", 0, 0, 0);
    bus3.req_valid = 0;
    step(); chk3("l3.t2", 0, 0, 0);
    step(); chk3("l3.t3", 1, W0, 0);
    step(); chk3("l3.t4", 0, 0, 0);

    // LATENCY=3 four back-to-back fetches
    for (int c = 0; c < 8; c++) begin
      bus3.req_valid = (c < 4);
      bus3.req_addr  = 32'(4 * (c % 4));
      step();
      if (c >= 2 && c < 6) chk3($sformatf("l3.b2b%0d", c), 1, words[c-2], 32'(4 * (c - 2)));
      else chk3($sformatf("l3.b2b%0d", c), 0, 0, 0);
    end

    // Stall with the pipe full, then drain
    for (int c = 0; c < 3; c++) begin
      bus3.req_valid = 1; bus3.req_addr = 32'(4 * c);
      step();
    end
    chk3("st.head", 1, W0, 0);
    bus3.resp_ready = 0; bus3.req_valid = 1; bus3.req_addr = 12; #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("st.ready%0d", c), 64'(bus3.req_ready), 64'd0);
      step();
      chk3($sformatf("st.hold%0d", c), 1, W0, 0);
    end
    bus3.resp_ready = 1; #1;
    check("st.release.ready", 64'(bus3.req_ready), 64'd1);
    step(); chk3("st.d1", 1, W1, 4);
    bus3.req_valid = 0;
    step(); chk3("st.d2", 1, W2, 8);
    step(); chk3("st.d3", 1, W3, 12);
    step(); chk3("st.d4", 0, 0, 0);

    // Flush with two fetches in flight
    bus3.req_valid = 1; bus3.req_addr = 0; step();
    bus3.req_addr = 4; step();
    bus3.flush = 1; bus3.req_addr = 8; #1;
    check("fl.ready", 64'(bus3.req_ready), 64'd0);
    step(); chk3("fl.c0", 0, 0, 0);
    bus3.flush = 0; bus3.req_valid = 0;
    for (int c = 1; c < 4; c++) begin
      step(); chk3($sformatf("fl.c%0d", c), 0, 0, 0);
    end
    bus3.req_valid = 1; bus3.req_addr = 4; step();
    bus3.req_valid = 0; step();
    step(); chk3("fl.after", 1, W1, 4);
    step(); chk3("fl.after_idle", 0, 0, 0);

    // Flush overrides a stall
    bus1.req_valid = 1; bus1.req_addr = 8; bus1.resp_ready = 0;
    step(); chk1("fs.head", 1, W2, 8, 0);
    bus1.req_valid = 0;
    step(); chk1("fs.hold", 1, W2, 8, 0);
    bus1.flush = 1;
    step(); chk1("fs.flushed", 0, 0, 0, 0);
    bus1.flush = 0; bus1.resp_ready = 1;

    // Fault / boundary fetches
    bus1.req_valid = 1; bus1.req_addr = 2;
`ifdef IMEM_ERR_EN
    step(); chk1("er.mis2", 1, 32'h0, 2, 1);
    bus1.req_addr = 144;
    step(); chk1("er.oor144", 1, 32'h0, 144, 1);
    bus1.req_addr = 140;
    step(); chk1("er.last140", 1, 32'hDEAD_BEEF, 140, 0);
`else
    step(); chk1("ne.raw2", 1, 32'h0005_8C09, 2, 0);
    bus1.req_addr = 142;
    step(); chk1("ne.tail142", 1, 32'hBEEF_0000, 142, 0);
    bus1.req_addr = 140;
    step(); chk1("ne.last140", 1, 32'hDEAD_BEEF, 140, 0);
`endif
    bus1.req_valid = 0;
    step(); chk1("er.idle", 0, 0, 0, 0);

    // Reset mid-stream (LATENCY=3) and during a stall (LATENCY=1)
    bus1.req_valid = 1; bus1.req_addr = 4; bus1.resp_ready = 0;
    bus3.req_valid = 1; bus3.req_addr = 0;
    step();
    bus1.req_valid = 0; bus3.req_addr = 4;
    step(); chk1("rs.stalled", 1, W1, 4, 0);
    reset = 1; bus3.req_valid = 0; #1;
    check("rs.ready1", 64'(bus1.req_ready), 64'd0);
    check("rs.ready3", 64'(bus3.req_ready), 64'd0);
    step();
    check("rs.valid1", 64'(bus1.resp_valid), 64'd0);
    check("rs.instr1", 64'(bus1.resp_instr), 64'd0);
    check("rs.addr1",  64'(bus1.resp_addr),  64'd0);
    check("rs.valid3", 64'(bus3.resp_valid), 64'd0);
    check("rs.instr3", 64'(bus3.resp_instr), 64'd0);
    reset = 0; bus1.resp_ready = 1;
    bus1.req_valid = 1; bus1.req_addr = 12;
    bus3.req_valid = 1; bus3.req_addr = 8;
    step(); chk1("rs.post1", 1, W3, 12, 0); chk3("rs.post3a", 0, 0, 0);
    bus1.req_valid = 0; bus3.req_valid = 0;
    step(); chk1("rs.post1idle", 0, 0, 0, 0); chk3("rs.post3b", 0, 0, 0);
    step(); chk3("rs.post3c", 1, W2, 8);
    bus1.req_valid = 1; bus1.req_addr = 0;
    step(); chk1("rs.mem0", 1, W0, 0, 0);
    bus1.req_valid = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
